pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program counter and instruction-fetch stage for the single-cycle MIPS core, directly upstream of the instruction decoder and PC-select lookups.
- Holds the PC, fetches one word per instruction from an instruction memory with a req/ack handshake, and presents a stable instruction to decode.
- Computes the next PC from the decoder's PC-select code, the jump/jal selects and the register value for jr, then advances when decode releases the instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max FETCH cycles without imem_ack before error; valid range 1..255.

Ports:
clk  in  1  core clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address, equal to pc_out.
imem_ack  in  1  memory returns data this cycle; sampled only while imem_req=1.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
instr_out  out  32  held instruction for decode.
instr_valid  out  1  instr_out is valid.
stall  in  1  decode or datapath not done; the instruction is held while high.
pc_out  out  32  address of the current instruction.
link_addr  out  32  pc_out+4, for the jal write to R31.
pc_sel  in  2  decoder select: 00 sequential, 01 beq taken, 10 bne taken, 11 jr.
branch_off  in  32  sign-extended word offset, already shifted left by 2.
jump_n  in  1  active-low jump select (0 = j).
jal_n  in  1  active-low jal select (0 = jal).
jr_target  in  32  Rs register value for jr.
fetch_err  out  1  sticky, set on memory timeout.
align_err  out  1  sticky, set on a misaligned jr target.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch):
  - pc_out=RESET_PC, instr_out=0, instr_valid=0, imem_req=0, fetch_err=0, align_err=0, wait counter=0, state=IDLE.
- Combinational outputs: imem_addr=pc_out; link_addr=pc_out+4, modulo 2^32.
- FSM states:
  - IDLE: entered only from reset. Goes to FETCH on the first clock edge after reset_n deasserts.
  - FETCH: imem_req=1. If imem_ack=1, register imem_rdata into instr_out, set instr_valid=1, go to HOLD. Otherwise increment the wait counter; when it reaches TIMEOUT-1 without ack, set fetch_err and go to ERROR. The counter clears on leaving FETCH.
  - HOLD: imem_req=0, instr_valid=1, instr_out stable. If stall=0 at the edge, load pc_out with next_pc, clear instr_valid and go to FETCH. If stall=1, hold everything.
  - ERROR: imem_req=0, instr_valid=0. Exit only by reset.
- Latency: ack in the first FETCH cycle gives instr_valid on the next cycle. Minimum throughput is 2 cycles per instruction.
- next_pc is evaluated in HOLD from the held instr_out. Priority, highest first:
  1. pc_sel=11: jr_target with bits [1:0] forced to 00. If jr_target[1:0]!=0, set align_err.
  2. jump_n=0 or jal_n=0: {link_addr[31:28], instr_out[25:0], 2'b00}.
  3. pc_sel=01 or 10: link_addr+branch_off.
  4. Otherwise: link_addr.
- Arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC sequential gives 0.
- imem_ack outside FETCH is ignored. imem_rdata is sampled only on the ack edge.
- Select inputs are ignored outside HOLD.
- Both error flags stay set until reset.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, HOLD, ERROR); PC-select codes SEL_SEQ=2'b00, SEL_BEQ=2'b01, SEL_BNE=2'b10, SEL_JR=2'b11; constant PC_STEP=4.
- Sub-module next_pc_calc: purely combinational. Inputs are pc_out, instr_out, pc_sel, jump_n, jal_n, branch_off and jr_target. Outputs are next_pc and misalign.
- The FSM, registers and counter stay in the top module.

Test Plan:
1. Reset with RESET_PC=0, memory acks on the first cycle, stall=0, pc_sel=00 -> imem_addr sequence 0,4,8,C with one req cycle each; instr_valid high every other cycle.
2. In HOLD at pc=32'h40, pc_sel=01, branch_off=32'hFFFF_FFF8 -> next fetch at 32'h3C. With pc_sel=10 and branch_off=32'h10 -> next fetch at 32'h54.
3. pc=32'h1000_0010, instr_out=32'h0C00_0100, jal_n=0 -> next fetch at 32'h1000_0400, and link_addr=32'h1000_0014 during HOLD. Then pc_sel=11 with jr_target=32'h1000_0014 -> next fetch at 32'h1000_0014, align_err=0.
4. jr_target=32'h0000_0203 -> next fetch at 32'h0000_0200, align_err=1 and remains set.
5. stall held high for 5 cycles in HOLD -> instr_out and pc_out unchanged and imem_req=0 throughout; PC advances on the first edge with stall=0.
6. TIMEOUT=4 and ack withheld -> fetch_err=1 after 4 FETCH cycles, imem_req drops to 0. Asserting reset_n=0 mid-FETCH drops imem_req in the same cycle and returns pc_out to RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_e;

    localparam logic [1:0]  SEL_SEQ = 2'b00;
    localparam logic [1:0]  SEL_BEQ = 2'b01;
    localparam logic [1:0]  SEL_BNE = 2'b10;
    localparam logic [1:0]  SEL_JR  = 2'b11;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Next-PC selection: jr > j/jal > taken branch > sequential, all modulo 2^32.
module next_pc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_out,
    input  logic [31:0] instr_out,
    input  logic [1:0]  pc_sel,
    input  logic        jump_n,
    input  logic        jal_n,
    input  logic [31:0] branch_off,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] link;
    logic        unused_opcode;

    assign link          = pc_out + PC_STEP;
    // Opcode bits are decoded upstream; only the jump index field matters here.
    assign unused_opcode = ^instr_out[31:26];

    // Priority mux for the next fetch address; jr target is word-aligned by force.
    always_comb begin
        next_pc  = link;
        misalign = 1'b0;
        if (pc_sel == SEL_JR) begin
            next_pc  = {jr_target[31:2], 2'b00};
            misalign = (jr_target[1:0] != 2'b00);
        end else if (!jump_n || !jal_n) begin
            next_pc  = {link[31:28], instr_out[25:0], 2'b00};
        end else if (pc_sel == SEL_BEQ || pc_sel == SEL_BNE) begin
            next_pc  = link + branch_off;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and one-word-at-a-time instruction fetch with req/ack handshake.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        stall,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_off,
    input  logic        jump_n,
    input  logic        jal_n,
    input  logic [31:0] jr_target,
    output logic        fetch_err,
    output logic        align_err
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [7:0]   wait_q, wait_d;
    logic         fetch_err_q, fetch_err_d;
    logic         align_err_q, align_err_d;
    logic [31:0]  next_pc;
    logic         misalign;

    next_pc_calc u_next_pc (
        .pc_out     (pc_q),
        .instr_out  (instr_q),
        .pc_sel     (pc_sel),
        .jump_n     (jump_n),
        .jal_n      (jal_n),
        .branch_off (branch_off),
        .jr_target  (jr_target),
        .next_pc    (next_pc),
        .misalign   (misalign)
    );

    // Request and valid decode straight from state so reset drops them at once.
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_HOLD);
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign link_addr   = pc_q + PC_STEP;
    assign instr_out   = instr_q;
    assign fetch_err   = fetch_err_q;
    assign align_err   = align_err_q;

    // Next-state: fetch until ack or timeout, hold until decode releases.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        wait_d      = wait_q;
        fetch_err_d = fetch_err_q;
        align_err_d = align_err_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    wait_d  = '0;
                    state_d = ST_HOLD;
                end else if (wait_q == WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    wait_d      = '0;
                    state_d     = ST_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_HOLD: begin
                // Selects only matter on the release edge.
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                    if (misalign) align_err_d = 1'b1;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            wait_q      <= '0;
            fetch_err_q <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            wait_q      <= wait_d;
            fetch_err_q <= fetch_err_d;
            align_err_q <= align_err_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, branches, jumps, stall, errors.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        stall;
    logic [31:0] pc_out;
    logic [31:0] link_addr;
    logic [1:0]  pc_sel;
    logic [31:0] branch_off;
    logic        jump_n;
    logic        jal_n;
    logic [31:0] jr_target;
    logic        fetch_err;
    logic        align_err;

    logic        ack_en;
    logic        ovr_en;
    logic [31:0] ovr_word;
    int          n_vec = 0;
    int          n_err = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
        .stall(stall), .pc_out(pc_out), .link_addr(link_addr), .pc_sel(pc_sel),
        .branch_off(branch_off), .jump_n(jump_n), .jal_n(jal_n),
        .jr_target(jr_target), .fetch_err(fetch_err), .align_err(align_err)
    );

    always #5 clk = ~clk;

    // Memory model: zero-wait ack when enabled; word tagged with its address.
    assign imem_ack = imem_req & ack_en;
    always_comb begin
        imem_rdata = 32'hA500_0000 ^ imem_addr;
        if (ovr_en) imem_rdata = ovr_word;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From HOLD: apply selects, release, check the new fetch address, ack it back to HOLD.
    task automatic adv(input string tag, input logic [1:0] sel, input logic jn,
                       input logic jaln, input logic [31:0] off, input logic [31:0] jr,
                       input logic [31:0] exp);
        pc_sel = sel; jump_n = jn; jal_n = jaln; branch_off = off; jr_target = jr;
        tick();
        chk({tag, "_addr"}, imem_addr, exp);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        pc_sel = 2'b00; jump_n = 1'b1; jal_n = 1'b1; branch_off = '0; jr_target = '0;
        tick();
        chk({tag, "_vld"}, {31'b0, instr_valid}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; pc_sel = 2'b00; branch_off = '0;
        jump_n = 1'b1; jal_n = 1'b1; jr_target = '0;
        ack_en = 1'b1; ovr_en = 1'b0; ovr_word = '0;
        tick(); tick();

        // reset state
        chk("rst_pc",   pc_out, 32'h0);
        chk("rst_req",  {31'b0, imem_req}, 32'd0);
        chk("rst_vld",  {31'b0, instr_valid}, 32'd0);
        chk("rst_ins",  instr_out, 32'h0);
        chk("rst_ferr", {31'b0, fetch_err}, 32'd0);
        chk("rst_aerr", {31'b0, align_err}, 32'd0);
        chk("rst_link", link_addr, 32'h4);

        // sequential fetch 0,4,8,C: one req cycle, then one valid cycle
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("seq_addr", imem_addr, 32'(4 * k));
            chk("seq_req",  {31'b0, imem_req}, 32'd1);
            chk("seq_nvld", {31'b0, instr_valid}, 32'd0);
            tick();
            chk("seq_hreq", {31'b0, imem_req}, 32'd0);
            chk("seq_vld",  {31'b0, instr_valid}, 32'd1);
            chk("seq_ins",  instr_out, 32'hA500_0000 | 32'(4 * k));
            if (k < 3) tick();
        end

        // branches from 0x40
        adv("jr40",  2'b11, 1'b1, 1'b1, 32'h0, 32'h40, 32'h40);
        adv("beq",   2'b01, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h3C);
        adv("jr40b", 2'b11, 1'b1, 1'b1, 32'h0, 32'h40, 32'h40);
        adv("bne",   2'b10, 1'b1, 1'b1, 32'h10, 32'h0, 32'h54);

        // jal with held instruction 0x0C000100 at 0x1000_0010
        ovr_en = 1'b1; ovr_word = 32'h0C00_0100;
        adv("jrjal", 2'b11, 1'b1, 1'b1, 32'h0, 32'h1000_0010, 32'h1000_0010);
        ovr_en = 1'b0;
        chk("jal_ins",  instr_out, 32'h0C00_0100);
        chk("jal_link", link_addr, 32'h1000_0014);
        adv("jal",   2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1000_0400);
        adv("jrret", 2'b11, 1'b1, 1'b1, 32'h0, 32'h1000_0014, 32'h1000_0014);
        chk("jr_aerr0", {31'b0, align_err}, 32'd0);

        // misaligned jr: forced aligned, flag sticky
        adv("jrmis", 2'b11, 1'b1, 1'b1, 32'h0, 32'h0000_0203, 32'h0000_0200);
        chk("aerr_set", {31'b0, align_err}, 32'd1);
        adv("seq204", 2'b00, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0000_0204);
        chk("aerr_hold", {31'b0, align_err}, 32'd1);

        // stall for 5 cycles in HOLD
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stl_ins", instr_out, 32'hA500_0204);
            chk("stl_pc",  pc_out, 32'h204);
            chk("stl_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("stl_rel", pc_out, 32'h208);
        chk("stl_rreq", {31'b0, imem_req}, 32'd1);
        tick();

        // 32-bit wrap
        adv("jrtop", 2'b11, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        chk("top_link", link_addr, 32'h0);
        adv("wrap",  2'b00, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        adv("seq4",  2'b00, 1'b1, 1'b1, 32'h0, 32'h0, 32'h4);

        // timeout: four unacked FETCH cycles
        ack_en = 1'b0;
        tick();
        chk("to_addr", imem_addr, 32'h8);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_req",  {31'b0, imem_req}, 32'd1);
            chk("to_ferr0", {31'b0, fetch_err}, 32'd0);
        end
        tick();
        chk("to_ferr", {31'b0, fetch_err}, 32'd1);
        chk("to_reqlo", {31'b0, imem_req}, 32'd0);
        chk("to_vld",  {31'b0, instr_valid}, 32'd0);
        ack_en = 1'b1;
        tick(); tick();
        chk("err_stk", {31'b0, fetch_err}, 32'd1);
        chk("err_req", {31'b0, imem_req}, 32'd0);

        // reset mid-FETCH from a nonzero PC
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        adv("jr80", 2'b11, 1'b1, 1'b1, 32'h0, 32'h80, 32'h80);
        ack_en = 1'b0;
        tick();
        chk("mf_req", {31'b0, imem_req}, 32'd1);
        chk("mf_pc",  pc_out, 32'h84);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_req",  {31'b0, imem_req}, 32'd0);
        chk("mr_pc",   pc_out, 32'h0);
        chk("mr_ferr", {31'b0, fetch_err}, 32'd0);
        chk("mr_vld",  {31'b0, instr_valid}, 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
